// File: rtl/mm_dmem_arbiter_if.sv
// Bundle of the CPU, debug and data-memory signals around mm_dmem_arbiter.
//   slave  : arbiter view (takes requests, drives grants, read returns and mem_*)
//   master : environment view (CPU, debug master and memory model)
// CPU port   : cpu_req/we/addr/wdata in, cpu_gnt/stall/rvalid/rdata out
// Debug port : dbg_req/we/lock/addr/wdata in, dbg_gnt/rvalid/rdata out
// Memory     : mem_en/we/addr/wdata out, mem_rdata in (valid one cycle after a read strobe)
interface mm_dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dbg_req;
   logic              dbg_we;
   logic              dbg_lock;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mm_dmem_arbiter.sv
// Shares the single-port MiniMIPS data memory between the CPU load/store port and a
// debug/loader port. CPU has priority; a starvation counter forces a debug grant after
// STARVE_LIM consecutive lost debug cycles, and dbg_lock keeps debug ownership for bursts.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : mm_dmem_arbiter_if.slave (CPU port, debug port, memory port)
module mm_dmem_arbiter #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_LIM = 4
) (
   input logic              clk,
   input logic              rst_n,
   mm_dmem_arbiter_if.slave bus
);
   typedef enum logic {StArb, StLock} state_e;
   typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDbg} owner_e;

   localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [3:0]        starve_q, starve_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              cpu_gnt, dbg_gnt, force_dbg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StArb;
         owner_q     <= OwnNone;
         starve_q    <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   // Arbitration and next state
   always_comb begin
      state_d   = state_q;
      starve_d  = starve_q;
      cpu_gnt   = 1'b0;
      dbg_gnt   = 1'b0;
      force_dbg = (starve_q == StarveLim);
      unique case (state_q)
         StArb: begin
            if (bus.dbg_req && (!bus.cpu_req || force_dbg)) begin
               dbg_gnt  = 1'b1;
               starve_d = '0;
               if (bus.dbg_lock) state_d = StLock;
            end else if (bus.cpu_req) begin
               cpu_gnt = 1'b1;
               if (bus.dbg_req && (starve_q < StarveLim)) starve_d = starve_q + 4'd1;
            end
         end
         StLock: begin
            starve_d = '0;
            dbg_gnt  = bus.dbg_req;
            // Leave after an unlocked grant or once debug stops requesting
            if (!bus.dbg_req || !bus.dbg_lock) state_d = StArb;
         end
      endcase
      // No access may issue while reset is held
      if (!rst_n) begin
         cpu_gnt = 1'b0;
         dbg_gnt = 1'b0;
      end
   end

   // Read return tracking: owner_q names the port whose read data arrives this cycle
   always_comb begin
      owner_d = OwnNone;
      if (cpu_gnt && !bus.cpu_we)      owner_d = OwnCpu;
      else if (dbg_gnt && !bus.dbg_we) owner_d = OwnDbg;
      cpu_rdata_d = (owner_q == OwnCpu) ? bus.mem_rdata : cpu_rdata_q;
      dbg_rdata_d = (owner_q == OwnDbg) ? bus.mem_rdata : dbg_rdata_q;
   end

   // Outputs; muxes fall back to 0 so nothing undriven leaks to the memory
   always_comb begin
      bus.cpu_gnt    = cpu_gnt;
      bus.dbg_gnt    = dbg_gnt;
      bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
      bus.cpu_rvalid = (owner_q == OwnCpu);
      bus.dbg_rvalid = (owner_q == OwnDbg);
      bus.cpu_rdata  = cpu_rdata_d;
      bus.dbg_rdata  = dbg_rdata_d;
      bus.mem_en     = cpu_gnt | dbg_gnt;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      if (cpu_gnt) begin
         bus.mem_we    = bus.cpu_we;
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
      end else if (dbg_gnt) begin
         bus.mem_we    = bus.dbg_we;
         bus.mem_addr  = bus.dbg_addr;
         bus.mem_wdata = bus.dbg_wdata;
      end
   end
endmodule
